// File: rtl/bitplane_feeder.sv
// bitplane_feeder: transmit side of the bit-serial matrix-vector interface.
// Holds a LANES x COLS matrix of DW-bit weights and ROWS activation vectors.
// Each activation row is streamed as DW bit-plane beats, MSB first. A beat
// carries, for every lane, the weights of that lane gated by the current
// activation bit. There is one output bus per weight column.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   w_valid/w_data/w_ready  weight-row load, one row k per accepted beat
//   w_reload              discard weights (only honoured in S_LA with acnt==0)
//   a_valid/a_data/a_ready  activation-row load, lane k at [k*DW+:DW]
//   out_valid, out_data1..4, out_last  registered beat stream, out_last on j==0
//   frame_done            one-cycle pulse the cycle after the final beat

// Per-lane gating: each column weight is ANDed with the selected activation bit.
module bitplane_lane #(
  parameter int DW   = 4,
  parameter int COLS = 4
) (
  input  logic                      a_bit,
  input  logic [COLS*DW-1:0]        w,
  output logic [COLS-1:0][DW-1:0]   g
);
  for (genvar c = 0; c < COLS; c++) begin : g_col
    assign g[c] = {DW{a_bit}} & w[c*DW +: DW];
  end
endmodule

module bitplane_feeder #(
  parameter int LANES = 32,
  parameter int DW    = 4,
  parameter int ROWS  = 4,
  parameter int COLS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_valid,
  input  logic [COLS*DW-1:0]    w_data,
  output logic                  w_ready,
  input  logic                  w_reload,
  input  logic                  a_valid,
  input  logic [LANES*DW-1:0]   a_data,
  output logic                  a_ready,
  output logic                  out_valid,
  output logic [LANES*DW-1:0]   out_data1,
  output logic [LANES*DW-1:0]   out_data2,
  output logic [LANES*DW-1:0]   out_data3,
  output logic [LANES*DW-1:0]   out_data4,
  output logic                  out_last,
  output logic                  frame_done
);
  localparam int WW    = $clog2(LANES);
  localparam int IW    = $clog2(ROWS);
  localparam int JW    = $clog2(DW);
  localparam int BW    = IW + JW;
  localparam int BEATS = ROWS * DW;

  typedef enum logic [1:0] {S_LW, S_LA, S_STR} state_t;
  state_t state, state_nx;

  logic [WW-1:0] wcnt;
  logic [IW-1:0] acnt;
  logic [BW-1:0] bcnt;

  logic [LANES-1:0][COLS*DW-1:0]       w_mem;
  logic [ROWS-1:0][LANES-1:0][DW-1:0]  a_mem;

  logic w_acc, a_acc, str, beat_end;
  assign w_acc    = w_valid & w_ready;
  assign a_acc    = a_valid & a_ready;
  assign str      = (state == S_STR);
  assign beat_end = (bcnt == BW'(BEATS - 1));

  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_LW;
    else     state <= state_nx;

  // Next-state logic; a row accepted alongside w_reload takes priority.
  always_comb begin
    state_nx = state;
    case (state)
      S_LW:    if (w_acc && wcnt == WW'(LANES - 1)) state_nx = S_LA;
      S_LA:    if (a_acc && acnt == IW'(ROWS - 1)) state_nx = S_STR;
               else if (w_reload && !a_valid && acnt == '0) state_nx = S_LW;
      S_STR:   if (beat_end) state_nx = S_LA;
      default: state_nx = S_LW;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_ready = 1'b0;
    a_ready = 1'b0;
    case (state)
      S_LW:    w_ready = 1'b1;
      S_LA:    a_ready = 1'b1;
      default: ;
    endcase
  end

  // Counters and stores. All counters wrap naturally back to 0 on their
  // final increment, which is exactly where each phase ends.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wcnt  <= '0;
      acnt  <= '0;
      bcnt  <= '0;
      w_mem <= '0;
      a_mem <= '0;
    end else begin
      if (w_acc) begin
        w_mem[wcnt] <= w_data;
        wcnt        <= wcnt + 1'b1;
      end
      if (a_acc) begin
        a_mem[acnt] <= a_data;
        acnt        <= acnt + 1'b1;
      end
      if (str) bcnt <= bcnt + 1'b1;
    end

  // Beat index: upper bits pick the row, lower bits count bit planes MSB first.
  logic [IW-1:0] bi;
  logic [JW-1:0] bj;
  assign bi = bcnt[BW-1:JW];
  assign bj = JW'(DW - 1) - bcnt[JW-1:0];

  logic [LANES-1:0][COLS-1:0][DW-1:0] g_all;
  logic [COLS-1:0][LANES-1:0][DW-1:0] beat;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    bitplane_lane #(.DW(DW), .COLS(COLS)) u_lane (
      .a_bit (a_mem[bi][k][bj]),
      .w     (w_mem[k]),
      .g     (g_all[k])
    );
    for (genvar c = 0; c < COLS; c++) begin : g_map
      assign beat[c][k] = g_all[k][c];
    end
  end

  // Output register stage. Data is forced to 0 outside the stream.
  // vld_pipe[1] delays the final-beat flag by one so frame_done follows it.
  logic [COLS-1:0][LANES*DW-1:0] out_q;
  logic [1:0]                    vld_pipe;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_q     <= '0;
      vld_pipe  <= '0;
    end else begin
      out_valid <= str;
      out_last  <= str && (bcnt[JW-1:0] == JW'(DW - 1));
      out_q     <= str ? beat : '0;
      vld_pipe  <= {vld_pipe[0], str && beat_end};
    end

  assign frame_done = vld_pipe[1];
  assign out_data1  = out_q[0];
  assign out_data2  = out_q[1];
  assign out_data3  = out_q[2];
  assign out_data4  = out_q[3];
endmodule

// File: tb/tb_bitplane_feeder.sv
module tb_bitplane_feeder;
  logic         clk = 1'b0;
  logic         rst;
  logic         w_valid, w_reload, a_valid;
  logic [15:0]  w_data;
  logic [127:0] a_data;
  logic         w_ready, a_ready, out_valid, out_last, frame_done;
  logic [127:0] out_data1, out_data2, out_data3, out_data4;

  bitplane_feeder dut (
    .clk(clk), .rst(rst),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready), .w_reload(w_reload),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .out_valid(out_valid), .out_data1(out_data1), .out_data2(out_data2),
    .out_data3(out_data3), .out_data4(out_data4),
    .out_last(out_last), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int err = 0;

  // Reference model: matrix and activation contents as written.
  logic [15:0]  wm [32];
  logic [3:0]   am [4][32];

  // Capture of 20 consecutive cycles starting the cycle after the 4th row.
  logic [127:0] cd [20][4];
  logic         cv [20];
  logic         cl [20];
  logic         cf [20];

  // Expected beat b (row b/4, bit 3-b%4) for column c.
  function automatic logic [127:0] exp_beat(int b, int c);
    logic [127:0] r;
    int i, j;
    r = '0;
    i = b / 4;
    j = 3 - (b % 4);
    for (int k = 0; k < 32; k++)
      if (am[i][k][j]) r[k*4 +: 4] = wm[k][c*4 +: 4];
    return r;
  endfunction

  // Plain dot product of activation row i with weight column c.
  function automatic int dot(int i, int c);
    int s;
    s = 0;
    for (int k = 0; k < 32; k++) s += int'(am[i][k]) * int'(wm[k][c*4 +: 4]);
    return s;
  endfunction

  // Receiver behaviour applied to captured beats of row i.
  function automatic int rx(int i, int c);
    int o, s;
    o = 0;
    for (int jj = 0; jj < 4; jj++) begin
      s = 0;
      for (int k = 0; k < 32; k++) s += int'(cd[1 + i*4 + jj][c][k*4 +: 4]);
      o = o * 2 + s;
    end
    return o;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_w();
    for (int k = 0; k < 32; k++) begin
      w_valid = 1'b1;
      w_data  = wm[k];
      cyc();
    end
    w_valid = 1'b0;
  endtask

  task automatic load_a(input int first, input int n);
    for (int r = first; r < first + n; r++) begin
      a_valid = 1'b1;
      for (int k = 0; k < 32; k++) a_data[k*4 +: 4] = am[r][k];
      cyc();
    end
    a_valid = 1'b0;
  endtask

  task automatic capture(input bit noise);
    for (int n = 0; n < 20; n++) begin
      cv[n] = out_valid;
      cl[n] = out_last;
      cf[n] = frame_done;
      cd[n][0] = out_data1; cd[n][1] = out_data2;
      cd[n][2] = out_data3; cd[n][3] = out_data4;
      if (noise) begin
        w_valid = 1'b1;
        w_data  = 16'($urandom);
      end
      cyc();
    end
    w_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    vec++; if (w_ready !== 1'b1) begin err++; $display("FAIL reset_w_ready got %b want 1", w_ready); end
    vec++; if (a_ready !== 1'b0) begin err++; $display("FAIL reset_a_ready got %b want 0", a_ready); end
    vec++; if (out_valid !== 1'b0 || out_last !== 1'b0 || frame_done !== 1'b0) begin
      err++; $display("FAIL reset_flags got v=%b l=%b fd=%b want 0", out_valid, out_last, frame_done);
    end
    vec++; if ({out_data1, out_data2, out_data3, out_data4} !== 512'd0) begin
      err++; $display("FAIL reset_data got %h want 0", out_data1);
    end
  endtask

  task automatic test_all_ones();
    logic [127:0] ones;
    ones = {32{4'hF}};
    for (int k = 0; k < 32; k++) begin
      wm[k] = 16'hFFFF;
      for (int i = 0; i < 4; i++) am[i][k] = 4'hF;
    end
    load_w();
    load_a(0, 4);
    capture(1'b0);
    for (int n = 0; n < 20; n++) begin
      vec++; if (cv[n] !== (n >= 1 && n <= 16)) begin
        err++; $display("FAIL ones_valid cyc %0d got %b want %b", n, cv[n], (n >= 1 && n <= 16));
      end
      vec++; if (cf[n] !== (n == 17)) begin
        err++; $display("FAIL ones_frame_done cyc %0d got %b want %b", n, cf[n], (n == 17));
      end
      vec++; if (cl[n] !== (n >= 1 && n <= 16 && (n % 4) == 0)) begin
        err++; $display("FAIL ones_last cyc %0d got %b", n, cl[n]);
      end
      for (int c = 0; c < 4; c++) begin
        vec++; if (cd[n][c] !== ((n >= 1 && n <= 16) ? ones : 128'd0)) begin
          err++; $display("FAIL ones_data cyc %0d col %0d got %h", n, c, cd[n][c]);
        end
      end
    end
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < 4; c++) begin
        vec++; if (rx(i, c) !== 7200) begin
          err++; $display("FAIL ones_rx row %0d col %0d got %0d want 7200", i, c, rx(i, c));
        end
      end
  endtask

  task automatic test_pattern_4321();
    logic [127:0] p1, p4;
    p1 = {32{4'h1}};
    p4 = {32{4'h4}};
    // Reload with no activation rows pending.
    w_reload = 1'b1; cyc(); w_reload = 1'b0;
    vec++; if (w_ready !== 1'b1) begin err++; $display("FAIL reload_acnt0 w_ready got %b want 1", w_ready); end
    for (int k = 0; k < 32; k++) begin
      wm[k] = 16'h4321;
      am[0][k] = 4'b1010;
      for (int i = 1; i < 4; i++) am[i][k] = 4'h0;
    end
    load_w();
    load_a(0, 4);
    capture(1'b0);
    for (int b = 0; b < 16; b++) begin
      if (b == 0 || b == 2) begin
        vec++; if (cd[1+b][0] !== p1 || cd[1+b][3] !== p4) begin
          err++; $display("FAIL p4321_set beat %0d got c0=%h c3=%h", b, cd[1+b][0], cd[1+b][3]);
        end
      end else begin
        vec++; if ({cd[1+b][0], cd[1+b][1], cd[1+b][2], cd[1+b][3]} !== 512'd0) begin
          err++; $display("FAIL p4321_zero beat %0d got c0=%h", b, cd[1+b][0]);
        end
      end
    end
    vec++; if (rx(0, 0) !== 320 || rx(0, 3) !== 1280) begin
      err++; $display("FAIL p4321_rx got O1=%0d O4=%0d want 320 1280", rx(0, 0), rx(0, 3));
    end
    for (int i = 1; i < 4; i++) begin
      vec++; if (rx(i, 0) !== 0 || rx(i, 3) !== 0) begin
        err++; $display("FAIL p4321_rx_zero row %0d got %0d %0d want 0", i, rx(i, 0), rx(i, 3));
      end
    end
  endtask

  task automatic test_random_frames();
    w_reload = 1'b1; cyc(); w_reload = 1'b0;
    // Activation strobes during weight loading must be ignored.
    for (int n = 0; n < 3; n++) begin
      a_valid = 1'b1; a_data = {4{32'($urandom)}};
      cyc();
      vec++; if (a_ready !== 1'b0 || out_valid !== 1'b0) begin
        err++; $display("FAIL lw_ignore_a got a_ready=%b out_valid=%b want 0 0", a_ready, out_valid);
      end
    end
    a_valid = 1'b0;
    for (int k = 0; k < 32; k++) wm[k] = 16'($urandom);
    load_w();
    // Two frames on the same weights; the first with weight-strobe noise.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 4; i++)
        for (int k = 0; k < 32; k++) am[i][k] = 4'($urandom_range(0, 15));
      load_a(0, 4);
      capture(f == 0);
      for (int n = 0; n < 20; n++) begin
        vec++; if (cv[n] !== (n >= 1 && n <= 16) || cf[n] !== (n == 17)) begin
          err++; $display("FAIL rand_timing frame %0d cyc %0d got v=%b fd=%b", f, n, cv[n], cf[n]);
        end
        if (n >= 1 && n <= 16)
          for (int c = 0; c < 4; c++) begin
            vec++; if (cd[n][c] !== exp_beat(n - 1, c)) begin
              err++; $display("FAIL rand_data frame %0d beat %0d col %0d got %h want %h",
                              f, n - 1, c, cd[n][c], exp_beat(n - 1, c));
            end
          end
      end
      for (int i = 0; i < 4; i++)
        for (int c = 0; c < 4; c++) begin
          vec++; if (rx(i, c) !== dot(i, c)) begin
            err++; $display("FAIL rand_rx frame %0d row %0d col %0d got %0d want %0d",
                            f, i, c, rx(i, c), dot(i, c));
          end
        end
    end
  endtask

  task automatic test_reload();
    int nv;
    w_reload = 1'b1; cyc(); w_reload = 1'b0;
    vec++; if (w_ready !== 1'b1) begin err++; $display("FAIL reload_go got w_ready=%b want 1", w_ready); end
    for (int k = 0; k < 32; k++) wm[k] = 16'($urandom);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 32; k++) am[i][k] = 4'($urandom_range(0, 15));
    load_w();
    // Row 0 together with reload: row wins, reload ignored.
    w_reload = 1'b1;
    load_a(0, 1);
    w_reload = 1'b0;
    vec++; if (w_ready !== 1'b0 || a_ready !== 1'b1) begin
      err++; $display("FAIL reload_with_row got w_ready=%b a_ready=%b want 0 1", w_ready, a_ready);
    end
    load_a(1, 1);
    w_reload = 1'b1; cyc(); w_reload = 1'b0;
    vec++; if (w_ready !== 1'b0 || a_ready !== 1'b1) begin
      err++; $display("FAIL reload_acnt2 got w_ready=%b a_ready=%b want 0 1", w_ready, a_ready);
    end
    load_a(2, 2);
    capture(1'b0);
    nv = 0;
    for (int n = 0; n < 20; n++) if (cv[n] === 1'b1) nv++;
    vec++; if (nv !== 16 || cf[17] !== 1'b1) begin
      err++; $display("FAIL reload_stream got beats=%0d fd=%b want 16 1", nv, cf[17]);
    end
    for (int b = 0; b < 16; b++) begin
      vec++; if (cd[1+b][1] !== exp_beat(b, 1)) begin
        err++; $display("FAIL reload_data beat %0d got %h want %h", b, cd[1+b][1], exp_beat(b, 1));
      end
    end
  endtask

  task automatic test_reset_midstream();
    int nv;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 32; k++) am[i][k] = 4'($urandom_range(1, 15));
    load_a(0, 4);
    for (int n = 0; n < 7; n++) cyc();
    vec++; if (out_valid !== 1'b1) begin err++; $display("FAIL mid_pre got out_valid=%b want 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    vec++; if (out_valid !== 1'b0 || out_last !== 1'b0 ||
               {out_data1, out_data2, out_data3, out_data4} !== 512'd0) begin
      err++; $display("FAIL mid_async got v=%b l=%b d1=%h want 0", out_valid, out_last, out_data1);
    end
    cyc();
    rst = 1'b0;
    cyc();
    vec++; if (w_ready !== 1'b1 || a_ready !== 1'b0) begin
      err++; $display("FAIL mid_after got w_ready=%b a_ready=%b want 1 0", w_ready, a_ready);
    end
    a_valid = 1'b1;
    nv = 0;
    for (int n = 0; n < 24; n++) begin
      if (n == 4) a_valid = 1'b0;
      if (out_valid === 1'b1) nv++;
      cyc();
    end
    vec++; if (nv !== 0) begin err++; $display("FAIL mid_no_beats got %0d want 0", nv); end
    for (int k = 0; k < 32; k++) wm[k] = 16'($urandom);
    load_w();
    load_a(0, 4);
    capture(1'b0);
    nv = 0;
    for (int n = 0; n < 20; n++) if (cv[n] === 1'b1) nv++;
    vec++; if (nv !== 16 || cf[17] !== 1'b1) begin
      err++; $display("FAIL mid_restream got beats=%0d fd=%b want 16 1", nv, cf[17]);
    end
    for (int c = 0; c < 4; c++) begin
      vec++; if (rx(3, c) !== dot(3, c)) begin
        err++; $display("FAIL mid_rx col %0d got %0d want %0d", c, rx(3, c), dot(3, c));
      end
    end
  endtask

  initial begin
    rst = 1'b1; w_valid = 1'b0; w_data = '0; w_reload = 1'b0;
    a_valid = 1'b0; a_data = '0;
    test_reset();
    test_all_ones();
    test_pattern_4321();
    test_random_frames();
    test_reload();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
